adc_poll_scheduler: RTL and testbench

ADC_POLL_SCHEDULER -- requirements
Module: adc_poll_scheduler

---
 rtl/adc_poll_scheduler_if.sv | 42 ++++
 rtl/adc_poll_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_adc_poll_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_poll_scheduler_if.sv
// Shared-I2C-master command/read-data ports plus the sample output stream of the ADC poll scheduler.
// master = scheduler side, slave = I2C master / mux / sample consumer side.
interface adc_poll_scheduler_if;
  logic [1:0]  bus_sel;
  logic        i2c_busy;
  logic [6:0]  i2c_cmd_address;
  logic        i2c_cmd_start;
  logic        i2c_cmd_read;
  logic        i2c_cmd_stop;
  logic        i2c_cmd_valid;
  logic        i2c_cmd_ready;
  logic [7:0]  i2c_rd_tdata;
  logic        i2c_rd_tvalid;
  logic        i2c_rd_tready;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  modport master (
    output bus_sel,
    input  i2c_busy,
    output i2c_cmd_address, i2c_cmd_start, i2c_cmd_read, i2c_cmd_stop, i2c_cmd_valid,
    input  i2c_cmd_ready,
    input  i2c_rd_tdata, i2c_rd_tvalid,
    output i2c_rd_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  bus_sel,
    output i2c_busy,
    input  i2c_cmd_address, i2c_cmd_start, i2c_cmd_read, i2c_cmd_stop, i2c_cmd_valid,
    output i2c_cmd_ready,
    output i2c_rd_tdata, i2c_rd_tvalid,
    input  i2c_rd_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/adc_poll_scheduler.sv
// Periodic sweep reading a 16-bit ADC sample over up to three muxed I2C buses; beat out one cycle after the low byte.
// Beats are held until m_axis_tready; ticks arriving mid-sweep are dropped and flagged as overrun.
module adc_poll_scheduler #(
  parameter logic [6:0]  DEV_ADDR = 7'h28,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [23:0]           period,
  input  logic [2:0]            enable,
  input  logic                  clear,
  adc_poll_scheduler_if.master  io,
  output logic                  busy,
  output logic                  overrun,
  output logic [2:0]            timeout_err,
  output logic [15:0]           sweep_count
);

  typedef enum logic [2:0] {IDLE, SEL, CMD0, RD0, CMD1, RD1, OUT, NEXT} state_t;

  state_t      state;
  logic [1:0]  cur_bus;
  logic [2:0]  en_q;
  logic [15:0] step_cnt;
  logic [7:0]  sample_hi;
  logic [15:0] sweep_cnt_q;
  logic [23:0] period_q;
  logic [23:0] tmr_cnt;
  logic        tick;
  logic [2:0]  rest_mask;
  logic        has_higher;
  logic        advance;
  logic        abort;

  function automatic logic [2:0] above(input logic [1:0] b);
    case (b)
      2'd0:    above = 3'b110;
      2'd1:    above = 3'b100;
      default: above = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      lowest = 2'd0;
    else if (m[1]) lowest = 2'd1;
    else           lowest = 2'd2;
  endfunction

  // Period is latched only at wrap; an idle (zero) period keeps reloading so a new value starts at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      tmr_cnt  <= '0;
    end else if (period_q == 24'd0 || tick) begin
      period_q <= period;
      tmr_cnt  <= '0;
    end else begin
      tmr_cnt <= tmr_cnt + 24'd1;
    end
  end

  assign tick        = (period_q != 24'd0) && (tmr_cnt == period_q - 24'd1);
  assign rest_mask   = en_q & above(cur_bus);
  assign has_higher  = |rest_mask;
  assign busy        = (state != IDLE);
  assign sweep_count = sweep_cnt_q;

  always_comb begin
    advance = 1'b0;
    case (state)
      SEL:        advance = !io.i2c_busy;
      CMD0, CMD1: advance = io.i2c_cmd_valid && io.i2c_cmd_ready;
      RD0, RD1:   advance = io.i2c_rd_tvalid && io.i2c_rd_tready;
      default:    advance = 1'b0;
    endcase
  end

  assign abort = (state inside {SEL, CMD0, RD0, CMD1, RD1}) && !advance
                 && (step_cnt == TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cur_bus            <= '0;
      en_q               <= '0;
      step_cnt           <= '0;
      sample_hi          <= '0;
      sweep_cnt_q        <= '0;
      overrun            <= 1'b0;
      timeout_err        <= '0;
      io.bus_sel         <= '0;
      io.i2c_cmd_address <= '0;
      io.i2c_cmd_start   <= 1'b0;
      io.i2c_cmd_read    <= 1'b0;
      io.i2c_cmd_stop    <= 1'b0;
      io.i2c_cmd_valid   <= 1'b0;
      io.i2c_rd_tready   <= 1'b0;
      io.m_axis_tdata    <= '0;
      io.m_axis_tuser    <= '0;
      io.m_axis_tvalid   <= 1'b0;
      io.m_axis_tlast    <= 1'b0;
    end else begin
      if (clear) begin
        overrun     <= 1'b0;
        timeout_err <= '0;
      end
      if (tick && state != IDLE) overrun <= 1'b1;
      step_cnt <= step_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (tick && enable != 3'b000) begin
            en_q       <= enable;
            cur_bus    <= lowest(enable);
            io.bus_sel <= lowest(enable);
            step_cnt   <= '0;
            state      <= SEL;
          end
        end
        SEL: begin
          if (advance) begin
            io.i2c_cmd_valid   <= 1'b1;
            io.i2c_cmd_address <= DEV_ADDR;
            io.i2c_cmd_start   <= 1'b1;
            io.i2c_cmd_read    <= 1'b1;
            io.i2c_cmd_stop    <= 1'b0;
            step_cnt           <= '0;
            state              <= CMD0;
          end
        end
        CMD0, CMD1: begin
          if (advance) begin
            io.i2c_cmd_valid   <= 1'b0;
            io.i2c_cmd_address <= '0;
            io.i2c_cmd_start   <= 1'b0;
            io.i2c_cmd_read    <= 1'b0;
            io.i2c_cmd_stop    <= 1'b0;
            io.i2c_rd_tready   <= 1'b1;
            step_cnt           <= '0;
            state              <= (state == CMD0) ? RD0 : RD1;
          end
        end
        RD0: begin
          if (advance) begin
            sample_hi          <= io.i2c_rd_tdata;
            io.i2c_rd_tready   <= 1'b0;
            io.i2c_cmd_valid   <= 1'b1;
            io.i2c_cmd_address <= DEV_ADDR;
            io.i2c_cmd_start   <= 1'b0;
            io.i2c_cmd_read    <= 1'b1;
            io.i2c_cmd_stop    <= 1'b1;
            step_cnt           <= '0;
            state              <= CMD1;
          end
        end
        RD1: begin
          if (advance) begin
            io.i2c_rd_tready <= 1'b0;
            io.m_axis_tvalid <= 1'b1;
            io.m_axis_tdata  <= {sample_hi, io.i2c_rd_tdata};
            io.m_axis_tuser  <= cur_bus;
            io.m_axis_tlast  <= !has_higher;
            state            <= OUT;
          end
        end
        OUT: begin
          if (io.m_axis_tready) begin
            io.m_axis_tvalid <= 1'b0;
            state            <= NEXT;
          end
        end
        NEXT: begin
          if (has_higher) begin
            cur_bus    <= lowest(rest_mask);
            io.bus_sel <= lowest(rest_mask);
            step_cnt   <= '0;
            state      <= SEL;
          end else begin
            sweep_cnt_q <= sweep_cnt_q + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A stuck handshake abandons this bus without a beat; the flag set wins over a same-cycle clear.
      if (abort) begin
        io.i2c_cmd_valid   <= 1'b0;
        io.i2c_cmd_address <= '0;
        io.i2c_cmd_start   <= 1'b0;
        io.i2c_cmd_read    <= 1'b0;
        io.i2c_cmd_stop    <= 1'b0;
        io.i2c_rd_tready   <= 1'b0;
        timeout_err        <= (clear ? 3'b000 : timeout_err) | (3'b001 << cur_bus);
        state              <= NEXT;
      end
    end
  end

endmodule

// File: tb/tb_adc_poll_scheduler.sv
// Directed bench for adc_poll_scheduler with a responsive I2C master model and a beat recorder.
module tb_adc_poll_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] period;
  logic [2:0]  enable;
  logic        clear;
  logic        busy;
  logic        overrun;
  logic [2:0]  timeout_err;
  logic [15:0] sweep_count;

  always #5 clk = ~clk;

  adc_poll_scheduler_if ifc ();

  adc_poll_scheduler #(.DEV_ADDR(7'h28), .TIMEOUT(16'd100)) dut (
    .clk         (clk),
    .rst         (rst),
    .period      (period),
    .enable      (enable),
    .clear       (clear),
    .io          (ifc),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .sweep_count (sweep_count)
  );

  // I2C master model: returns hi_byte after a start command, lo_byte after a stop command.
  logic       stall_bus1 = 1'b0;
  logic       stall_lo   = 1'b0;
  logic       hi_phase   = 1'b0;
  logic [7:0] hi_byte    = 8'h1A;
  logic [7:0] lo_byte    = 8'hBC;

  always @(posedge clk)
    if (ifc.i2c_cmd_valid && ifc.i2c_cmd_ready) hi_phase <= ifc.i2c_cmd_start;

  assign ifc.i2c_rd_tvalid = ifc.i2c_rd_tready && !(stall_bus1 && ifc.bus_sel == 2'd1)
                             && !(stall_lo && !hi_phase);
  assign ifc.i2c_rd_tdata  = hi_phase ? hi_byte : lo_byte;

  logic [15:0] q_dat[$];
  logic [1:0]  q_usr[$];
  logic        q_last[$];
  logic        bus1_seen = 1'b0;
  logic        busy_seen = 1'b0;
  int          bad_cmd   = 0;

  always @(negedge clk) begin
    if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
      q_dat.push_back(ifc.m_axis_tdata);
      q_usr.push_back(ifc.m_axis_tuser);
      q_last.push_back(ifc.m_axis_tlast);
    end
    if (ifc.bus_sel == 2'd1) bus1_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (ifc.i2c_cmd_valid && ifc.i2c_cmd_ready &&
        (ifc.i2c_cmd_address != 7'h28 || !ifc.i2c_cmd_read || ifc.i2c_cmd_start == ifc.i2c_cmd_stop))
      bad_cmd++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [15:0] d,
                            input logic [1:0] u, input logic l);
    logic [18:0] obs;
    if (idx < q_dat.size()) obs = {q_last[idx], q_usr[idx], q_dat[idx]};
    else                    obs = '1;
    check(tag, 32'(obs), 32'({l, u, d}));
  endtask

  task automatic wait_sweeps(input string tag, input logic [15:0] target, input int budget);
    int i = 0;
    while (sweep_count !== target && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(sweep_count), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    q_dat.delete();
    q_usr.delete();
    q_last.delete();
    bus1_seen = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, 32'({busy, overrun, timeout_err, ifc.m_axis_tvalid, ifc.m_axis_tlast,
                               ifc.i2c_cmd_valid, ifc.i2c_cmd_start, ifc.i2c_cmd_read,
                               ifc.i2c_cmd_stop, ifc.i2c_rd_tready}), 32'h0);
    check({tag, "_sel_addr"}, 32'({ifc.bus_sel, ifc.i2c_cmd_address}), 32'h0);
    check({tag, "_beat"}, 32'({ifc.m_axis_tuser, ifc.m_axis_tdata}), 32'h0);
    check({tag, "_sweeps"}, 32'(sweep_count), 32'h0);
  endtask

  initial begin
    logic [18:0] held;
    int          unstable;
    int          i;

    rst = 1'b1; period = '0; enable = '0; clear = 1'b0;
    ifc.i2c_busy = 1'b0; ifc.i2c_cmd_ready = 1'b1; ifc.m_axis_tready = 1'b1;
    step(3);
    check_reset_outputs("reset");

    // Zero period: timer silent, no sweep ever starts.
    enable = 3'b111;
    rst = 1'b0;
    busy_seen = 1'b0;
    step(300);
    check("p0_busy_seen", 32'(busy_seen), 32'h0);
    check("p0_sweeps", 32'(sweep_count), 32'h0);

    // All three buses.
    period = 24'd1000; enable = 3'b111;
    do_reset();
    wait_sweeps("v1_sweep_count", 16'd1, 1600);
    enable = 3'b000;
    check("v1_beats", 32'(q_dat.size()), 32'd3);
    check_beat("v1_b0", 0, 16'h1ABC, 2'd0, 1'b0);
    check_beat("v1_b1", 1, 16'h1ABC, 2'd1, 1'b0);
    check_beat("v1_b2", 2, 16'h1ABC, 2'd2, 1'b1);

    // Buses 0 and 2, with the shared master initially busy.
    hi_byte = 8'h5A; lo_byte = 8'hC3;
    period = 24'd100; enable = 3'b101; ifc.i2c_busy = 1'b1;
    do_reset();
    i = 0;
    while (!busy && i < 200) begin step(1); i++; end
    check("v2_started", 32'(busy), 32'h1);
    step(20);
    check("v2_sel_hold", 32'({ifc.i2c_cmd_valid, ifc.bus_sel}), 32'h0);
    ifc.i2c_busy = 1'b0;
    wait_sweeps("v2_sweep_count", 16'd1, 300);
    enable = 3'b000;
    check("v2_beats", 32'(q_dat.size()), 32'd2);
    check_beat("v2_b0", 0, 16'h5AC3, 2'd0, 1'b0);
    check_beat("v2_b1", 1, 16'h5AC3, 2'd2, 1'b1);
    check("v2_bus1_seen", 32'(bus1_seen), 32'h0);
    check("v2_overrun", 32'(overrun), 32'h0);

    // Bus 1 never returns read data.
    hi_byte = 8'h81; lo_byte = 8'h7E;
    stall_bus1 = 1'b1; period = 24'd1000; enable = 3'b111;
    do_reset();
    wait_sweeps("v3_sweep_count", 16'd1, 1600);
    enable = 3'b000;
    check("v3_timeout_err", 32'(timeout_err), 32'h2);
    check("v3_beats", 32'(q_dat.size()), 32'd2);
    check_beat("v3_b0", 0, 16'h817E, 2'd0, 1'b0);
    check_beat("v3_b1", 1, 16'h817E, 2'd2, 1'b1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("v3_clear", 32'(timeout_err), 32'h0);
    stall_bus1 = 1'b0;

    // Consumer stalls across several ticks.
    hi_byte = 8'h1A; lo_byte = 8'hBC;
    period = 24'd500; enable = 3'b001; ifc.m_axis_tready = 1'b0;
    do_reset();
    i = 0;
    while (!ifc.m_axis_tvalid && i < 1000) begin step(1); i++; end
    check("v4_valid", 32'(ifc.m_axis_tvalid), 32'h1);
    held = {ifc.m_axis_tlast, ifc.m_axis_tuser, ifc.m_axis_tdata};
    unstable = 0;
    repeat (2000) begin
      step(1);
      if ({ifc.m_axis_tlast, ifc.m_axis_tuser, ifc.m_axis_tdata} !== held || !ifc.m_axis_tvalid)
        unstable++;
    end
    check("v4_stable", 32'(unstable), 32'h0);
    check("v4_overrun", 32'(overrun), 32'h1);
    check("v4_no_beat_yet", 32'(q_dat.size()), 32'd0);
    enable = 3'b000;
    ifc.m_axis_tready = 1'b1;
    wait_sweeps("v4_sweep_count", 16'd1, 20);
    check("v4_beats", 32'(q_dat.size()), 32'd1);
    check_beat("v4_b0", 0, 16'h1ABC, 2'd0, 1'b1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("v4_clear", 32'(overrun), 32'h0);

    // Reset while bus 0 waits for its low byte.
    period = 24'd50; enable = 3'b011; stall_lo = 1'b1;
    do_reset();
    i = 0;
    while (!(ifc.i2c_rd_tready && !hi_phase) && i < 300) begin step(1); i++; end
    check("v5_in_rd1", 32'({ifc.i2c_rd_tready, hi_phase, ifc.bus_sel}), 32'h8);
    rst = 1'b1;
    step(1);
    check_reset_outputs("v5_reset");
    check("v5_no_beat", 32'(q_dat.size()), 32'd0);
    step(2);
    rst = 1'b0;
    stall_lo = 1'b0;
    wait_sweeps("v5_sweep_count", 16'd1, 300);
    enable = 3'b000;
    check("v5_beats", 32'(q_dat.size()), 32'd2);
    check_beat("v5_b0", 0, 16'h1ABC, 2'd0, 1'b0);
    check_beat("v5_b1", 1, 16'h1ABC, 2'd1, 1'b1);

    // Completed-sweep counter wraps.
    period = 24'd20; enable = 3'b001;
    do_reset();
    dut.sweep_cnt_q = 16'hFFFF;
    wait_sweeps("v6_wrap", 16'h0000, 100);
    enable = 3'b000;
    check("v6_beats", 32'(q_dat.size()), 32'd1);

    check("cmd_fields", 32'(bad_cmd), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
